torreta_controle_disparo: RTL and testbench

//  Fire-control sequencer for the turret. It drives the firing datapath (arm servo, trigger,

---
 rtl/torreta_controle_disparo.sv | 152 +++++++++++++++
 tb/tb_torreta_controle_disparo.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/torreta_controle_disparo.sv
// Fire-control sequencer: arm -> fire -> reload -> cooldown cycle per threat,
// plus ownership of the magazine round counter.
module torreta_controle_disparo #(
    parameter int N_MUNICAO  = 4,
    parameter int CAPACIDADE = 15,
    parameter int T_ARMAR    = 25_000_000,
    parameter int T_DISPARO  = 5_000_000,
    parameter int T_RECARGA  = 25_000_000,
    parameter int T_ESPERA   = 50_000_000,
    parameter int N_TIMER    = 27
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 ligar,
    input  logic                 ameaca_detectada,
    input  logic                 posicao_pronto,
    input  logic                 recarregar_municao,
    output logic                 armar_disparo,
    output logic                 disparar,
    output logic                 recarregar_disparo,
    output logic [N_MUNICAO-1:0] contagem_municao,
    output logic                 sem_municao,
    output logic                 ocupado,
    output logic [3:0]           db_estado
);

    typedef enum logic [3:0] {
        INICIAL      = 4'h0,
        OCIOSO       = 4'h1,
        ARMANDO      = 4'h2,
        DISPARANDO   = 4'h3,
        RECARREGANDO = 4'h4,
        ESPERA       = 4'h5,
        SEM_MUNICAO  = 4'hF
    } estado_t;

    localparam logic [N_TIMER-1:0]   FIM_ARMAR   = N_TIMER'(T_ARMAR - 1);
    localparam logic [N_TIMER-1:0]   FIM_DISPARO = N_TIMER'(T_DISPARO - 1);
    localparam logic [N_TIMER-1:0]   FIM_RECARGA = N_TIMER'(T_RECARGA - 1);
    localparam logic [N_TIMER-1:0]   FIM_ESPERA  = N_TIMER'(T_ESPERA - 1);
    localparam logic [N_MUNICAO-1:0] CARGA_CHEIA = N_MUNICAO'(CAPACIDADE);

    estado_t              estado;
    estado_t              estado_prox;
    logic [N_TIMER-1:0]   timer;
    logic                 estado_temporizado;
    logic                 municao_zero;
    logic                 ameaca_valida;
    logic                 tiro_concluido;
    logic                 recarga_aceita;

    assign estado_temporizado = (estado == ARMANDO) || (estado == DISPARANDO) ||
                                (estado == RECARREGANDO) || (estado == ESPERA);
    assign municao_zero   = (contagem_municao == '0);
    assign ameaca_valida  = ligar && ameaca_detectada;
    assign tiro_concluido = (estado == DISPARANDO) && (timer == FIM_DISPARO);
    assign recarga_aceita = recarregar_municao &&
                            ((estado == OCIOSO) || (estado == SEM_MUNICAO));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= INICIAL;
        end else begin
            estado <= estado_prox;
        end
    end

    // Timer restarts on every state change so each timed state lasts exactly T_x cycles.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timer <= '0;
        end else if ((estado_prox != estado) || !estado_temporizado) begin
            timer <= '0;
        end else begin
            timer <= timer + N_TIMER'(1);
        end
    end

    // The decrement only happens on a committed shot, which requires a non-empty magazine.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            contagem_municao <= CARGA_CHEIA;
        end else if (recarga_aceita) begin
            contagem_municao <= CARGA_CHEIA;
        end else if (tiro_concluido && !municao_zero) begin
            contagem_municao <= contagem_municao - N_MUNICAO'(1);
        end
    end

    // NOTE: estado_prox gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        estado_prox = estado;
        unique case (estado)
            INICIAL: estado_prox = OCIOSO;
            OCIOSO: begin
                if (municao_zero) begin
                    estado_prox = SEM_MUNICAO;
                end else if (ameaca_valida && posicao_pronto) begin
                    estado_prox = ARMANDO;
                end
            end
            ARMANDO: begin
                if (!ameaca_valida) begin
                    estado_prox = OCIOSO;
                end else if (timer == FIM_ARMAR) begin
                    estado_prox = DISPARANDO;
                end
            end
            DISPARANDO: begin
                if (timer == FIM_DISPARO) begin
                    estado_prox = RECARREGANDO;
                end
            end
            RECARREGANDO: begin
                if (timer == FIM_RECARGA) begin
                    estado_prox = ESPERA;
                end
            end
            ESPERA: begin
                if (timer == FIM_ESPERA) begin
                    estado_prox = municao_zero ? SEM_MUNICAO : OCIOSO;
                end
            end
            SEM_MUNICAO: begin
                if (recarregar_municao) begin
                    estado_prox = OCIOSO;
                end
            end
            default: estado_prox = INICIAL;
        endcase
    end

    always_comb begin
        armar_disparo      = 1'b0;
        disparar           = 1'b0;
        recarregar_disparo = 1'b0;
        ocupado            = estado_temporizado;
        unique case (estado)
            ARMANDO:      armar_disparo      = 1'b1;
            DISPARANDO:   disparar           = 1'b1;
            RECARREGANDO: recarregar_disparo = 1'b1;
            default:      ;
        endcase
    end

    assign sem_municao = municao_zero;
    assign db_estado   = estado;

endmodule

// File: tb/tb_torreta_controle_disparo.sv
// Bench for torreta_controle_disparo: directed scenarios followed by random
// stimulus, all checked every cycle against a schedule-based reference model.
module tb_torreta_controle_disparo;

    localparam int CAP = 3;
    localparam int TA  = 4;
    localparam int TD  = 2;
    localparam int TR  = 3;
    localparam int TE  = 2;
    localparam int NM  = 4;
    localparam int DURACAO_TIRO = TA + TD + TR + TE;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          ligar = 1'b0;
    logic          ameaca_detectada = 1'b0;
    logic          posicao_pronto = 1'b0;
    logic          recarregar_municao = 1'b0;
    logic          armar_disparo;
    logic          disparar;
    logic          recarregar_disparo;
    logic [NM-1:0] contagem_municao;
    logic          sem_municao;
    logic          ocupado;
    logic [3:0]    db_estado;

    torreta_controle_disparo #(
        .N_MUNICAO(NM), .CAPACIDADE(CAP), .T_ARMAR(TA), .T_DISPARO(TD),
        .T_RECARGA(TR), .T_ESPERA(TE), .N_TIMER(27)
    ) dut (
        .clock(clock), .reset(reset), .ligar(ligar),
        .ameaca_detectada(ameaca_detectada), .posicao_pronto(posicao_pronto),
        .recarregar_municao(recarregar_municao), .armar_disparo(armar_disparo),
        .disparar(disparar), .recarregar_disparo(recarregar_disparo),
        .contagem_municao(contagem_municao), .sem_municao(sem_municao),
        .ocupado(ocupado), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    int n_testes = 0;
    int n_falhas = 0;

    // Model: a shot is a fixed schedule measured by its age since arming began.
    typedef enum {M_INICIAL, M_OCIOSO, M_TIRO, M_VAZIO} fase_t;
    fase_t m_fase;
    int    m_idade;
    int    m_cont;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_testes++;
        assert (obs === exp) else begin
            n_falhas++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int em_faixa(input int lo, input int hi);
        return (m_fase == M_TIRO && m_idade >= lo && m_idade < hi) ? 1 : 0;
    endfunction

    function automatic int m_db();
        case (m_fase)
            M_INICIAL: return 0;
            M_OCIOSO:  return 1;
            M_VAZIO:   return 15;
            default: begin
                if (m_idade < TA)           return 2;
                if (m_idade < TA + TD)      return 3;
                if (m_idade < TA + TD + TR) return 4;
                return 5;
            end
        endcase
    endfunction

    task automatic modelo_reset();
        m_fase  = M_INICIAL;
        m_idade = 0;
        m_cont  = CAP;
    endtask

    task automatic modelo_passo();
        int cont_antes;
        cont_antes = m_cont;
        case (m_fase)
            M_INICIAL: m_fase = M_OCIOSO;
            M_OCIOSO: begin
                if (recarregar_municao) m_cont = CAP;
                if (cont_antes == 0) begin
                    m_fase = M_VAZIO;
                end else if (ligar && ameaca_detectada && posicao_pronto) begin
                    m_fase  = M_TIRO;
                    m_idade = 0;
                end
            end
            M_TIRO: begin
                if (m_idade < TA && !(ligar && ameaca_detectada)) begin
                    m_fase = M_OCIOSO;
                end else if (m_idade == DURACAO_TIRO - 1) begin
                    m_fase = (m_cont == 0) ? M_VAZIO : M_OCIOSO;
                end else begin
                    if (m_idade == TA + TD - 1) m_cont = m_cont - 1;
                    m_idade++;
                end
            end
            M_VAZIO: begin
                if (recarregar_municao) begin
                    m_cont = CAP;
                    m_fase = M_OCIOSO;
                end
            end
        endcase
    endtask

    task automatic check_all();
        check("db_estado", 32'(db_estado), 32'(m_db()));
        check("armar_disparo", 32'(armar_disparo), 32'(em_faixa(0, TA)));
        check("disparar", 32'(disparar), 32'(em_faixa(TA, TA + TD)));
        check("recarregar_disparo", 32'(recarregar_disparo), 32'(em_faixa(TA + TD, TA + TD + TR)));
        check("contagem_municao", 32'(contagem_municao), 32'(m_cont));
        check("sem_municao", 32'(sem_municao), 32'((m_cont == 0) ? 1 : 0));
        check("ocupado", 32'(ocupado), 32'((m_fase == M_TIRO) ? 1 : 0));
    endtask

    task automatic tick();
        @(posedge clock);
        if (!reset) modelo_reset();
        else        modelo_passo();
        @(negedge clock);
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic ameaca_total(input logic v);
        ligar            = v;
        ameaca_detectada = v;
        posicao_pronto   = v;
    endtask

    initial begin
        modelo_reset();
        @(negedge clock);
        check_all();
        reset = 1'b1;
        tick();
        check("pos_reset_ocioso", 32'(db_estado), 32'd1);

        // Drive into DISPARANDO, then reset asynchronously between edges.
        ameaca_total(1'b1);
        ticks(1 + TA + 1);
        check("antes_reset_disparando", 32'(disparar), 32'd1);
        #2 reset = 1'b0;
        #1 modelo_reset();
        check_all();
        check("reset_disparar", 32'(disparar), 32'd0);
        check("reset_contagem", 32'(contagem_municao), 32'(CAP));
        @(negedge clock);
        reset = 1'b1;
        tick();
        check("reset_depois_ocioso", 32'(db_estado), 32'd1);

        // Threat held for one full cycle: next arming the cycle after ESPERA.
        ticks(1 + DURACAO_TIRO + 1);
        check("ciclo_completo_contagem", 32'(contagem_municao), 32'(CAP - 1));
        check("ciclo_completo_rearma", 32'(db_estado), 32'd2);

        // Threat dropped at ARMANDO cycle 2: abort, no round used.
        tick();
        ameaca_detectada = 1'b0;
        tick();
        check("aborto_ocioso", 32'(db_estado), 32'd1);
        check("aborto_contagem", 32'(contagem_municao), 32'(CAP - 1));
        ticks(3);

        // Threat dropped during DISPARANDO: shot still completes.
        ameaca_total(1'b1);
        ticks(1 + TA);
        check("comprometido_disparando", 32'(db_estado), 32'd3);
        ligar = 1'b0;
        ameaca_detectada = 1'b0;
        ticks(TD - 1 + TR + TE + 1);
        check("comprometido_contagem", 32'(contagem_municao), 32'(CAP - 2));
        check("comprometido_ocioso", 32'(db_estado), 32'd1);

        // Last round, with a refill pulse during RECARREGANDO that must be ignored.
        ameaca_total(1'b1);
        ticks(1 + TA + TD);
        check("recarga_ignorada_estado", 32'(db_estado), 32'd4);
        recarregar_municao = 1'b1;
        tick();
        recarregar_municao = 1'b0;
        check("recarga_ignorada_contagem", 32'(contagem_municao), 32'd0);
        ticks(TR - 2 + TE + 1);
        check("vazio_estado", 32'(db_estado), 32'hF);
        check("vazio_flag", 32'(sem_municao), 32'd1);
        ticks(5);
        check("vazio_sem_armar", 32'(armar_disparo), 32'd0);
        recarregar_municao = 1'b1;
        tick();
        recarregar_municao = 1'b0;
        check("recarga_contagem", 32'(contagem_municao), 32'(CAP));
        check("recarga_ocioso", 32'(db_estado), 32'd1);

        // Random segments of held input levels with sporadic refill pulses.
        for (int seg = 0; seg < 150; seg++) begin
            int len;
            ligar            = ($urandom_range(0, 9) != 0);
            ameaca_detectada = ($urandom_range(0, 9) < 8);
            posicao_pronto   = ($urandom_range(0, 3) != 0);
            len = $urandom_range(1, 5);
            for (int k = 0; k < len; k++) begin
                recarregar_municao = ($urandom_range(0, 19) == 0);
                tick();
            end
            recarregar_municao = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_testes, n_falhas);
        $finish;
    end

endmodule
